// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with DATA_WIDTH-bit MSB-first words, per-transfer CPOL/CPHA,
// NUM_CS one-hot active-low chip selects, programmable CS setup/hold and multi-word bursts
// that keep CS low between words.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           request one word (accepted in IDLE with a valid cs_sel, or in HOLD)
//   cpol, cpha      SPI mode, latched at start from IDLE
//   cs_sel          target device index, latched at start from IDLE
//   data_to_send    word to shift out, latched at every accepted start
//   hold_cs         keep CS low after this word (burst continues in HOLD)
//   cs_release      in HOLD: end the burst
//   SPI_MISO        serial data in
//   data_received   last received word, updated with done
//   busy            high during CS setup, shifting and CS hold
//   done            one-cycle pulse per completed word
//   SPI_SCLK, SPI_MOSI, SPI_CS   SPI bus outputs (all registered)
module spi_master_multi #(
  parameter int unsigned CLK_FREQUENCY   = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY  = 500_000,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned NUM_CS          = 4,
  parameter int unsigned CS_SETUP_CYCLES = 10,
  parameter int unsigned CS_HOLD_CYCLES  = 10,
  localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CSW-1:0]        cs_sel,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  input  logic                  hold_cs,
  input  logic                  cs_release,
  input  logic                  SPI_MISO,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  busy,
  output logic                  done,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  output logic [NUM_CS-1:0]     SPI_CS
);

  localparam int unsigned HALF    = CLK_FREQUENCY / SCLK_FREQUENCY / 2;
  localparam int unsigned MAX_A   = (HALF > CS_SETUP_CYCLES) ? HALF : CS_SETUP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > CS_HOLD_CYCLES) ? MAX_A : CS_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CSW:0] CS_LIMIT = (CSW + 1)'(NUM_CS);

  // Reject configurations the timing scheme cannot support.
  generate
    if (HALF < 2) begin : g_half_check
      $error("spi_master_multi: CLK_FREQUENCY/SCLK_FREQUENCY/2 must be >= 2");
    end
    if (DATA_WIDTH < 2) begin : g_width_check
      $error("spi_master_multi: DATA_WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_HOLD,
    S_CS_HOLD
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;       // cycles until the next event (SCLK edge / phase end)
  logic [BIT_W-1:0]      bit_cnt;   // bits not yet completed by a trailing edge
  logic                  lead;      // next SCLK edge is a leading edge
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  start_ok;
  logic                  edge_now;

  assign start_ok = start && ({1'b0, cs_sel} < CS_LIMIT);

  // The setup phase ends with the first SCLK edge; SHIFT emits edges until all bits are done.
  assign edge_now = (cnt == '0) &&
                    ((state == S_CS_SETUP) || ((state == S_SHIFT) && (bit_cnt != '0)));

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      lead          <= 1'b1;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      hold_q        <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      data_received <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      SPI_SCLK      <= 1'b0;
      SPI_MOSI      <= 1'b0;
      SPI_CS        <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          SPI_SCLK <= cpol;
          if (start_ok) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            hold_q  <= hold_cs;
            SPI_CS  <= ~(NUM_CS'(1) << cs_sel);
            busy    <= 1'b1;
            cnt     <= CNT_W'(CS_SETUP_CYCLES - 1);
            bit_cnt <= BIT_W'(DATA_WIDTH);
            lead    <= 1'b1;
            // CPHA=0 presents the MSB as soon as CS falls.
            if (!cpha) begin
              SPI_MOSI <= data_to_send[DATA_WIDTH-1];
              tx_sr    <= {data_to_send[DATA_WIDTH-2:0], 1'b0};
            end else begin
              tx_sr <= data_to_send;
            end
            state <= S_CS_SETUP;
          end
        end

        S_CS_SETUP, S_SHIFT: begin
          if (edge_now) begin
            state    <= S_SHIFT;
            cnt      <= CNT_W'(HALF - 1);
            SPI_SCLK <= ~SPI_SCLK;
            lead     <= ~lead;
            if (lead) begin
              if (cpha_q) begin
                SPI_MOSI <= tx_sr[DATA_WIDTH-1];
                tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              end else begin
                rx_sr <= {rx_sr[DATA_WIDTH-2:0], SPI_MISO};
              end
            end else begin
              bit_cnt <= bit_cnt - BIT_W'(1);
              if (cpha_q) begin
                rx_sr <= {rx_sr[DATA_WIDTH-2:0], SPI_MISO};
              end else if (bit_cnt != BIT_W'(1)) begin
                // No MOSI update after the final bit.
                SPI_MOSI <= tx_sr[DATA_WIDTH-1];
                tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Half a period after the last edge: word complete.
            done          <= 1'b1;
            data_received <= rx_sr;
            SPI_SCLK      <= cpol_q;
            if (hold_q) begin
              busy  <= 1'b0;
              state <= S_HOLD;
            end else begin
              cnt   <= CNT_W'(CS_HOLD_CYCLES - 1);
              state <= S_CS_HOLD;
            end
          end
        end

        S_HOLD: begin
          SPI_SCLK <= cpol_q;
          if (start) begin
            // Next word of the burst: device and mode stay as latched.
            hold_q  <= hold_cs;
            busy    <= 1'b1;
            cnt     <= CNT_W'(HALF - 2);
            bit_cnt <= BIT_W'(DATA_WIDTH);
            lead    <= 1'b1;
            if (!cpha_q) begin
              SPI_MOSI <= data_to_send[DATA_WIDTH-1];
              tx_sr    <= {data_to_send[DATA_WIDTH-2:0], 1'b0};
            end else begin
              tx_sr <= data_to_send;
            end
            state <= S_SHIFT;
          end else if (cs_release) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(CS_HOLD_CYCLES - 1);
            state <= S_CS_HOLD;
          end
        end

        S_CS_HOLD: begin
          if (cnt == '0) begin
            SPI_CS <= '1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed, self-checking bench for spi_master_multi.
// Three builds share one clock: 8-bit/4 CS (main), 16-bit/4 CS, 8-bit/3 CS.
module tb_spi_master_multi;

  localparam int unsigned CLKF  = 100_000_000;
  localparam int unsigned SCLKF = 12_500_000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main build
  logic       start, cpol, cpha, hold_cs, cs_release, miso, loop, miso_m;
  logic [1:0] cs_sel;
  logic [7:0] data_to_send, data_received;
  logic       busy, done, sclk, mosi;
  logic [3:0] cs;
  assign miso = loop ? mosi : miso_m;

  // 16-bit build, always looped back
  logic        start16, cpol16, cpha16, hold16, rel16, miso16;
  logic [1:0]  cs_sel16;
  logic [15:0] data16, rx16;
  logic        busy16, done16, sclk16, mosi16;
  logic [3:0]  cs16;
  assign miso16 = mosi16;

  // 3-CS build
  logic       start3, cpol3, cpha3, hold3, rel3, miso3;
  logic [1:0] cs_sel3;
  logic [7:0] data3, rx3;
  logic       busy3, done3, sclk3, mosi3;
  logic [2:0] cs3;

  spi_master_multi #(
    .CLK_FREQUENCY(CLKF), .SCLK_FREQUENCY(SCLKF), .DATA_WIDTH(8), .NUM_CS(4),
    .CS_SETUP_CYCLES(3), .CS_HOLD_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
    .data_to_send(data_to_send), .hold_cs(hold_cs), .cs_release(cs_release),
    .SPI_MISO(miso), .data_received(data_received), .busy(busy), .done(done),
    .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_CS(cs)
  );

  spi_master_multi #(
    .CLK_FREQUENCY(CLKF), .SCLK_FREQUENCY(SCLKF), .DATA_WIDTH(16), .NUM_CS(4),
    .CS_SETUP_CYCLES(3), .CS_HOLD_CYCLES(3)
  ) dut16 (
    .clk(clk), .rst(rst), .start(start16), .cpol(cpol16), .cpha(cpha16), .cs_sel(cs_sel16),
    .data_to_send(data16), .hold_cs(hold16), .cs_release(rel16),
    .SPI_MISO(miso16), .data_received(rx16), .busy(busy16), .done(done16),
    .SPI_SCLK(sclk16), .SPI_MOSI(mosi16), .SPI_CS(cs16)
  );

  spi_master_multi #(
    .CLK_FREQUENCY(CLKF), .SCLK_FREQUENCY(SCLKF), .DATA_WIDTH(8), .NUM_CS(3),
    .CS_SETUP_CYCLES(3), .CS_HOLD_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cpol(cpol3), .cpha(cpha3), .cs_sel(cs_sel3),
    .data_to_send(data3), .hold_cs(hold3), .cs_release(rel3),
    .SPI_MISO(miso3), .data_received(rx3), .busy(busy3), .done(done3),
    .SPI_SCLK(sclk3), .SPI_MOSI(mosi3), .SPI_CS(cs3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edges, edges16, mosi_bad, cs_gap, dones, cs3_low, busy3_n, done3_n;
  logic sclk_p, mosi_p, sclk16_p, slv_en, burst_mon;
  logic [7:0] slv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge, and update the bus monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sclk != sclk_p) begin
      edges++;
      // Mode-3 subunit: drive next bit on each leading (falling) edge.
      if (slv_en && sclk_p && !sclk) begin
        miso_m = slv[7];
        slv    = {slv[6:0], 1'b0};
      end
    end
    if ((mosi != mosi_p) && !(sclk_p && !sclk)) mosi_bad++;
    if (burst_mon && (cs == 4'hF)) cs_gap++;
    if (done) dones++;
    if (sclk16 != sclk16_p) edges16++;
    if (cs3 != 3'b111) cs3_low++;
    if (busy3) busy3_n++;
    if (done3) done3_n++;
    sclk_p   = sclk;
    mosi_p   = mosi;
    sclk16_p = sclk16;
  endtask

  // Bounded wait for a done pulse; returns its cycle number relative to t0.
  task automatic wait_done(input int which, input int t0, input string tag, output int at);
    logic seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if ((which == 0 && done) || (which == 1 && done16)) begin
        seen = 1'b1;
        at   = cyc - t0;
      end
    end
    check({tag, "_timeout"}, 32'(seen), 'h1);
  endtask

  initial begin
    int t0, at;
    logic idle;
    rst = 1'b1;
    start = 0; cpol = 0; cpha = 0; hold_cs = 0; cs_release = 0; loop = 1; miso_m = 0;
    cs_sel = 0; data_to_send = 0;
    start16 = 0; cpol16 = 0; cpha16 = 0; hold16 = 0; rel16 = 0; cs_sel16 = 0; data16 = 0;
    start3 = 0; cpol3 = 0; cpha3 = 0; hold3 = 0; rel3 = 0; miso3 = 0; cs_sel3 = 0; data3 = 0;
    slv_en = 0; slv = 0; burst_mon = 0;
    edges = 0; edges16 = 0; mosi_bad = 0; cs_gap = 0; dones = 0;
    cs3_low = 0; busy3_n = 0; done3_n = 0;
    sclk_p = 0; mosi_p = 0; sclk16_p = 0;
    tick(); tick();

    // Reset state
    check("rst_cs", 32'(cs), 'hF);
    check("rst_sclk", 32'(sclk), 'h0);
    check("rst_mosi", 32'(mosi), 'h0);
    check("rst_busy", 32'(busy), 'h0);
    check("rst_done", 32'(done), 'h0);
    check("rst_data", 32'(data_received), 'h0);
    rst = 1'b0;
    tick();

    // 1: mode 0, cs_sel=2, 0xA5 loopback
    cpol = 0; cpha = 0; cs_sel = 2; data_to_send = 8'hA5; hold_cs = 0; loop = 1;
    tick();
    edges = 0; t0 = cyc; start = 1; tick(); start = 0;
    check("t1_cs_c1", 32'(cs), 'b1011);
    check("t1_busy_c1", 32'(busy), 'h1);
    check("t1_mosi_msb", 32'(mosi), 'h1);
    wait_done(0, t0, "t1", at);
    check("t1_done_cycle", 32'(at), 'd68);
    check("t1_data", 32'(data_received), 'hA5);
    check("t1_edges", 32'(edges), 'd16);
    check("t1_sclk_idle", 32'(sclk), 'h0);
    tick(); tick();
    check("t1_cs_c70", 32'(cs), 'b1011);
    tick();
    check("t1_cs_c71", 32'(cs), 'hF);
    check("t1_busy_c71", 32'(busy), 'h0);

    // 2: mode 3, send 0xC3, subunit answers 0x3C
    cpol = 1; cpha = 1; cs_sel = 0; data_to_send = 8'hC3; loop = 0;
    slv = 8'h3C; slv_en = 1; miso_m = 0;
    tick(); tick();
    check("t2_idle_sclk", 32'(sclk), 'h1);
    edges = 0; mosi_bad = 0; t0 = cyc; start = 1; tick(); start = 0;
    check("t2_cs_c1", 32'(cs), 'b1110);
    wait_done(0, t0, "t2", at);
    check("t2_done_cycle", 32'(at), 'd68);
    check("t2_data", 32'(data_received), 'h3C);
    check("t2_edges", 32'(edges), 'd16);
    check("t2_mosi_on_fall_only", 32'(mosi_bad), 'h0);
    check("t2_sclk_idle", 32'(sclk), 'h1);
    slv_en = 0;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      idle = (cs == 4'hF) && !busy;
    end
    check("t2_back_idle", 32'(idle), 'h1);

    // 3a: burst 0x12 (hold) then 0x34 (release via hold_cs=0)
    cpol = 0; cpha = 0; cs_sel = 1; loop = 1; data_to_send = 8'h12; hold_cs = 1;
    tick();
    t0 = cyc; start = 1; tick(); start = 0;
    burst_mon = 1; cs_gap = 0;
    check("t3_cs_c1", 32'(cs), 'b1101);
    wait_done(0, t0, "t3w1", at);
    check("t3_w1_done_cycle", 32'(at), 'd68);
    check("t3_w1_data", 32'(data_received), 'h12);
    check("t3_w1_busy", 32'(busy), 'h0);
    tick(); tick();
    check("t3_hold_busy", 32'(busy), 'h0);
    check("t3_hold_cs", 32'(cs), 'b1101);
    check("t3_hold_sclk", 32'(sclk), 'h0);
    data_to_send = 8'h34; hold_cs = 0; cs_sel = 3;
    t0 = cyc; start = 1; tick(); start = 0;
    check("t3_w2_busy", 32'(busy), 'h1);
    check("t3_w2_cs", 32'(cs), 'b1101);
    wait_done(0, t0, "t3w2", at);
    check("t3_w2_done_cycle", 32'(at), 'd68);
    check("t3_w2_data", 32'(data_received), 'h34);
    tick(); tick();
    check("t3_w2_cs_d2", 32'(cs), 'b1101);
    burst_mon = 0;
    tick();
    check("t3_w2_cs_d3", 32'(cs), 'hF);
    check("t3_w2_busy_d3", 32'(busy), 'h0);
    check("t3_cs_gap", 32'(cs_gap), 'h0);

    // 3b: held word 0x5A, then cs_release from HOLD
    cs_sel = 1; data_to_send = 8'h5A; hold_cs = 1;
    tick();
    t0 = cyc; start = 1; tick(); start = 0;
    burst_mon = 1; cs_gap = 0;
    wait_done(0, t0, "t3w3", at);
    check("t3_w3_data", 32'(data_received), 'h5A);
    tick(); tick();
    cs_release = 1; tick(); cs_release = 0;
    check("t3_rel_busy", 32'(busy), 'h1);
    tick(); tick();
    check("t3_rel_cs_r3", 32'(cs), 'b1101);
    burst_mon = 0;
    tick();
    check("t3_rel_cs_r4", 32'(cs), 'hF);
    check("t3_rel_busy_r4", 32'(busy), 'h0);
    check("t3_rel_cs_gap", 32'(cs_gap), 'h0);

    // 4: 16-bit build, mode 1, 0xBEEF loopback
    cpol16 = 0; cpha16 = 1; cs_sel16 = 3; data16 = 16'hBEEF;
    tick();
    edges16 = 0; t0 = cyc; start16 = 1; tick(); start16 = 0;
    check("t4_cs_c1", 32'(cs16), 'b0111);
    wait_done(1, t0, "t4", at);
    check("t4_done_cycle", 32'(at), 'd132);
    check("t4_data", 32'(rx16), 'hBEEF);
    check("t4_edges", 32'(edges16), 'd32);

    // 5: reset after the 5th SCLK edge, then a start while busy
    cpol = 0; cpha = 0; cs_sel = 0; data_to_send = 8'hFF; hold_cs = 0; loop = 1;
    tick();
    edges = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < 100 && edges < 5; i++) tick();
    check("t5_edges_before_rst", 32'(edges), 'd5);
    check("t5_sclk_before_rst", 32'(sclk), 'h1);
    rst = 1; tick(); rst = 0;
    check("t5_rst_cs", 32'(cs), 'hF);
    check("t5_rst_sclk", 32'(sclk), 'h0);
    check("t5_rst_busy", 32'(busy), 'h0);
    check("t5_rst_done", 32'(done), 'h0);
    check("t5_rst_data", 32'(data_received), 'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_done_after_abort", 32'(dones), 'h0);
    data_to_send = 8'h81; dones = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) tick();
    data_to_send = 8'h7E; start = 1; tick(); start = 0;
    idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      idle = (cs == 4'hF) && !busy;
    end
    for (int i = 0; i < 5; i++) tick();
    check("t5_back_idle", 32'(idle), 'h1);
    check("t5_single_done", 32'(dones), 'h1);
    check("t5_data", 32'(data_received), 'h81);

    // 6: 3-CS build, cs_sel=3 is out of range
    cs_sel3 = 3; data3 = 8'h99; cs3_low = 0; busy3_n = 0; done3_n = 0;
    start3 = 1; tick(); start3 = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t6_cs", 32'(cs3), 'b111);
    check("t6_cs_low_cycles", 32'(cs3_low), 'h0);
    check("t6_busy_cycles", 32'(busy3_n), 'h0);
    check("t6_done_count", 32'(done3_n), 'h0);
    cs_sel3 = 2; start3 = 1; tick(); start3 = 0;
    check("t6_valid_cs", 32'(cs3), 'b011);
    check("t6_valid_busy", 32'(busy3), 'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
